// File: rtl/spart_bus_echo_engine.sv
// spart_bus_echo_engine: SPART bring-up bus master on the cache-side memory port.
// Polls the status register, reads BURST words from the data register into a
// local buffer, then polls for TX space and writes them back in the same order.
// Optional poll timeout is enabled by defining SPART_ECHO_TIMEOUT_EN.
module spart_bus_echo_engine #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 28,
  parameter int unsigned       BURST     = 4,
  parameter logic [ADDR_W-1:0] DATA_ADDR = 28'h8000000,
  parameter logic [ADDR_W-1:0] STAT_ADDR = 28'h8000001,
  parameter int unsigned       RX_BIT    = 1,
  parameter int unsigned       TX_BIT    = 0,
  parameter int unsigned       AUTO_RUN  = 1,
  parameter int unsigned       TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       batch_cnt,
  output logic              error
);

  localparam int unsigned    PTR_W    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BURST - 1);

  // Reject parameter sets the buffer pointer and poll counter cannot represent
  if (BURST < 1 || BURST > 256 || TIMEOUT < 1) begin : g_bad_params
    $error("spart_bus_echo_engine: BURST must be 1..256 and TIMEOUT >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_RP_REQ, S_RP_WAIT, S_RD_REQ, S_RD_WAIT,
    S_WP_REQ, S_WP_WAIT, S_WR_REQ, S_WR_WAIT, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         batch_q, batch_d;
  logic                buf_we;
  logic [DATA_W-1:0]   buf_mem [BURST];

`ifdef SPART_ECHO_TIMEOUT_EN
  localparam int unsigned PCNT_W = $clog2(TIMEOUT + 1);
  logic [PCNT_W-1:0]   poll_q, poll_d;
  logic                error_q, error_d;
`endif

  // Next-state and registered-output logic for the poll/read/poll/write loop
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    batch_d = batch_q;
    buf_we  = 1'b0;
`ifdef SPART_ECHO_TIMEOUT_EN
    poll_d  = poll_q;
    error_d = error_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef SPART_ECHO_TIMEOUT_EN
        if (!error_q && (AUTO_RUN != 0 || start)) state_d = S_RP_REQ;
`else
        if (AUTO_RUN != 0 || start) state_d = S_RP_REQ;
`endif
      end
      S_RP_REQ, S_WP_REQ: begin
        // A leftover ready from the previous access must drop before issuing
        if (!mem_ready) begin
          valid_d = 1'b1;
          rw_d    = 1'b0;
          addr_d  = STAT_ADDR;
          state_d = (state_q == S_RP_REQ) ? S_RP_WAIT : S_WP_WAIT;
        end
      end
      S_RD_REQ: begin
        if (!mem_ready) begin
          valid_d = 1'b1;
          rw_d    = 1'b0;
          addr_d  = DATA_ADDR;
          state_d = S_RD_WAIT;
        end
      end
      S_WR_REQ: begin
        if (!mem_ready) begin
          valid_d = 1'b1;
          rw_d    = 1'b1;
          addr_d  = DATA_ADDR;
          wdata_d = buf_mem[ptr_q];
          state_d = S_WR_WAIT;
        end
      end
      S_RP_WAIT, S_WP_WAIT: begin
        if (mem_ready) begin
          valid_d = 1'b0;
          rw_d    = 1'b0;
          addr_d  = '0;
          if ((state_q == S_RP_WAIT) ? mem_rdata[RX_BIT] : mem_rdata[TX_BIT]) begin
            state_d = (state_q == S_RP_WAIT) ? S_RD_REQ : S_WR_REQ;
`ifdef SPART_ECHO_TIMEOUT_EN
            poll_d  = '0;
`endif
          end else begin
            state_d = (state_q == S_RP_WAIT) ? S_RP_REQ : S_WP_REQ;
`ifdef SPART_ECHO_TIMEOUT_EN
            poll_d = poll_q + PCNT_W'(1);
            if (poll_d == PCNT_W'(TIMEOUT)) begin
              error_d = 1'b1;
              done_d  = 1'b1;
              poll_d  = '0;
              ptr_d   = '0;
              state_d = S_IDLE;
            end
`endif
          end
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (mem_ready) begin
          valid_d = 1'b0;
          rw_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          buf_we  = (state_q == S_RD_WAIT);
          if (ptr_q == LAST_PTR) begin
            ptr_d   = '0;
            state_d = (state_q == S_RD_WAIT) ? S_WP_REQ : S_FIN;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = (state_q == S_RD_WAIT) ? S_RP_REQ : S_WP_REQ;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        batch_d = batch_q + 16'd1;
        state_d = (AUTO_RUN != 0) ? S_RP_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      batch_q <= '0;
`ifdef SPART_ECHO_TIMEOUT_EN
      poll_q  <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      batch_q <= batch_d;
`ifdef SPART_ECHO_TIMEOUT_EN
      poll_q  <= poll_d;
      error_q <= error_d;
`endif
    end
  end

  // Echo buffer; contents need no reset since every slot is written before use
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[ptr_q] <= mem_rdata;
  end

  assign mem_valid = valid_q;
  assign mem_rw    = rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign batch_cnt = batch_q;
`ifdef SPART_ECHO_TIMEOUT_EN
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_spart_bus_echo_engine.sv
// Bench for spart_bus_echo_engine: three instances (BURST=4 one-shot,
// BURST=1 auto-run, BURST=4 with TIMEOUT=8) each driven by a simple SPART slave
// that answers one cycle after a request.
module tb_spart_bus_echo_engine;

  localparam int unsigned NI     = 3;
  localparam logic [27:0] DATA_A = 28'h8000000;
  localparam logic [27:0] STAT_A = 28'h8000001;

  logic        clk;
  logic        rst       [NI];
  logic        start     [NI];
  logic        mem_valid [NI];
  logic        mem_rw    [NI];
  logic [27:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];
  logic        mem_ready [NI];
  logic        busy      [NI];
  logic        done      [NI];
  logic [15:0] batch_cnt [NI];
  logic        error     [NI];

  // Slave model state and observation counters
  int          fail_polls [NI];
  logic        force_rdy  [NI];
  int          stat_rd    [NI];
  int          data_rd    [NI];
  int          wr_cnt     [NI];
  int          done_cnt   [NI];
  int          bad_addr   [NI];
  int          early_valid[NI];
  int          rd_before_wr[NI];
  int          stat_before_data[NI];
  logic [31:0] rd_tab [NI][4];
  logic [31:0] rd_log [NI][16];
  logic [31:0] wr_log [NI][16];

  int checks;
  int errors;

  typedef struct packed {
    logic [31:0]      fails;
    logic [3:0][31:0] d;
    logic [31:0]      exp_first;
    logic [31:0]      exp_total;
    logic [15:0]      exp_batch;
  } vec_t;

  vec_t vecs [3];

  spart_bus_echo_engine #(.BURST(4), .AUTO_RUN(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .mem_valid(mem_valid[0]), .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
    .busy(busy[0]), .done(done[0]), .batch_cnt(batch_cnt[0]), .error(error[0])
  );

  spart_bus_echo_engine #(.BURST(1), .AUTO_RUN(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .mem_valid(mem_valid[1]), .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
    .busy(busy[1]), .done(done[1]), .batch_cnt(batch_cnt[1]), .error(error[1])
  );

  spart_bus_echo_engine #(.BURST(4), .AUTO_RUN(0), .TIMEOUT(8)) u_dut2 (
    .clk(clk), .rst(rst[2]), .start(start[2]),
    .mem_valid(mem_valid[2]), .mem_rw(mem_rw[2]), .mem_addr(mem_addr[2]),
    .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2]), .mem_ready(mem_ready[2]),
    .busy(busy[2]), .done(done[2]), .batch_cnt(batch_cnt[2]), .error(error[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPART slave: one-cycle response, status failures first, then status 3
  initial begin
    for (int k = 0; k < NI; k++) begin
      mem_ready[k] = 1'b0;
      mem_rdata[k] = 32'h0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
        if (done[k]) done_cnt[k]++;
        if (force_rdy[k]) begin
          if (mem_valid[k]) early_valid[k]++;
          mem_ready[k] = 1'b1;
        end else if (mem_valid[k] && !mem_ready[k]) begin
          mem_ready[k] = 1'b1;
          if (mem_rw[k]) begin
            if (wr_cnt[k] == 0) rd_before_wr[k] = data_rd[k];
            wr_log[k][wr_cnt[k] % 16] = mem_wdata[k];
            wr_cnt[k]++;
            if (mem_addr[k] != DATA_A) bad_addr[k]++;
            mem_rdata[k] = 32'h0;
          end else if (mem_addr[k] == STAT_A) begin
            stat_rd[k]++;
            if (fail_polls[k] > 0) begin
              fail_polls[k]--;
              mem_rdata[k] = 32'h0;
            end else begin
              mem_rdata[k] = 32'h3;
            end
          end else if (mem_addr[k] == DATA_A) begin
            if (data_rd[k] == 0) stat_before_data[k] = stat_rd[k];
            mem_rdata[k] = rd_tab[k][data_rd[k] % 4];
            rd_log[k][data_rd[k] % 16] = mem_rdata[k];
            data_rd[k]++;
          end else begin
            bad_addr[k]++;
          end
        end else begin
          mem_ready[k] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr(input int k);
    stat_rd[k] = 0; data_rd[k] = 0; wr_cnt[k] = 0; done_cnt[k] = 0;
    bad_addr[k] = 0; early_valid[k] = 0;
    rd_before_wr[k] = -1; stat_before_data[k] = -1;
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int n);
    int cyc;
    cyc = 0;
    while (done_cnt[k] < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_within_budget", 32'(done_cnt[k] >= n), 32'd1);
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      start[k] = 1'b0;
      force_rdy[k] = 1'b0;
      fail_polls[k] = 0;
      for (int i = 0; i < 4; i++) rd_tab[k][i] = 32'h0;
      clr(k);
    end
    rd_tab[1][0] = 32'hA5A5_0001;
    rd_tab[1][1] = 32'h5A5A_0002;
    rd_tab[1][2] = 32'hFFFF_0003;
    rd_tab[1][3] = 32'h0000_0004;

    //                  fails  d[3]          d[2]          d[1]          d[0]           first total batch
    vecs[0] = '{fails: 32'd0, d: {32'h44, 32'h33, 32'h22, 32'h11},
                exp_first: 32'd1, exp_total: 32'd8,  exp_batch: 16'd1};
    vecs[1] = '{fails: 32'd5, d: {32'h8000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678},
                exp_first: 32'd6, exp_total: 32'd13, exp_batch: 16'd2};
    vecs[2] = '{fails: 32'd2, d: {32'h0BAD_F00D, 32'h7FFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF},
                exp_first: 32'd3, exp_total: 32'd10, exp_batch: 16'd3};

    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("reset_mem_valid", 32'(mem_valid[0]), 32'd0);
    chk("reset_mem_addr",  32'(mem_addr[0]),  32'd0);
    chk("reset_busy",      32'(busy[0]),      32'd0);
    chk("reset_done",      32'(done[0]),      32'd0);
    chk("reset_batch_cnt", 32'(batch_cnt[0]), 32'd0);
    chk("reset_error",     32'(error[0]),     32'd0);

    // Table-driven one-shot batches on the BURST=4 instance
    for (int v = 0; v < 3; v++) begin
      clr(0);
      fail_polls[0] = int'(vecs[v].fails);
      for (int i = 0; i < 4; i++) rd_tab[0][i] = vecs[v].d[i];
      pulse_start(0);
      wait_done(0, 1);
      chk("busy_at_done",  32'(busy[0]),      32'd0);
      chk("batch_cnt",     32'(batch_cnt[0]), 32'(vecs[v].exp_batch));
      repeat (5) @(negedge clk);
      chk("done_once",     32'(done_cnt[0]),  32'd1);
      chk("data_reads",    32'(data_rd[0]),   32'd4);
      chk("data_writes",   32'(wr_cnt[0]),    32'd4);
      chk("reads_before_first_write", 32'(rd_before_wr[0]), 32'd4);
      chk("polls_before_first_read",  32'(stat_before_data[0]), vecs[v].exp_first);
      chk("total_status_polls",       32'(stat_rd[0]), vecs[v].exp_total);
      chk("bad_addr",      32'(bad_addr[0]),  32'd0);
      for (int i = 0; i < 4; i++) chk("echo_data", wr_log[0][i], vecs[v].d[i]);
    end

    // Ready already high: no request until it drops; second start while busy ignored
    clr(0);
    rd_tab[0][0] = 32'h1; rd_tab[0][1] = 32'h2; rd_tab[0][2] = 32'h3; rd_tab[0][3] = 32'h4;
    force_rdy[0] = 1'b1;
    pulse_start(0);
    repeat (3) begin
      @(negedge clk);
      chk("valid_held_off_by_ready", 32'(mem_valid[0]), 32'd0);
    end
    force_rdy[0] = 1'b0;
    pulse_start(0);
    wait_done(0, 1);
    repeat (20) @(negedge clk);
    chk("early_valid",       32'(early_valid[0]), 32'd0);
    chk("no_dup_polls",      32'(stat_rd[0]),     32'd8);
    chk("no_dup_reads",      32'(data_rd[0]),     32'd4);
    chk("single_batch",      32'(done_cnt[0]),    32'd1);
    chk("idle_after_batch",  32'(busy[0]),        32'd0);
    chk("batch_cnt_4",       32'(batch_cnt[0]),   32'd4);

    // Reset while a write is waiting for ready
    clr(0);
    pulse_start(0);
    cyc = 0;
    while (!(mem_valid[0] && mem_rw[0]) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_wr_wait", 32'(mem_valid[0] && mem_rw[0]), 32'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_valid", 32'(mem_valid[0]), 32'd0);
    chk("rst_mid_busy",      32'(busy[0]),      32'd0);
    chk("rst_mid_batch_cnt", 32'(batch_cnt[0]), 32'd0);
    chk("rst_mid_done",      32'(done[0]),      32'd0);
    rst[0] = 1'b0;
    @(negedge clk);

    // Auto-run, BURST=1: three back-to-back batches without start
    clr(1);
    rst[1] = 1'b0;
    wait_done(1, 3);
    chk("auto_batch_cnt", 32'(batch_cnt[1]), 32'd3);
    chk("auto_writes",    32'(wr_cnt[1] >= 3), 32'd1);
    chk("auto_bad_addr",  32'(bad_addr[1]),   32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("auto_echo_equals_read", wr_log[1][i], rd_log[1][i]);
      chk("auto_read_value",       rd_log[1][i], rd_tab[1][i]);
    end
    rst[1] = 1'b1;

    // Status never ready on the TIMEOUT=8 instance
    clr(2);
    fail_polls[2] = 1000000;
    rst[2] = 1'b0;
    pulse_start(2);
`ifdef SPART_ECHO_TIMEOUT_EN
    wait_done(2, 1);
    chk("timeout_error",     32'(error[2]),     32'd1);
    chk("timeout_polls",     32'(stat_rd[2]),   32'd8);
    chk("timeout_idle",      32'(busy[2]),      32'd0);
    chk("timeout_batch_cnt", 32'(batch_cnt[2]), 32'd0);
    pulse_start(2);
    repeat (10) @(negedge clk);
    chk("start_ignored_busy",  32'(busy[2]),     32'd0);
    chk("start_ignored_polls", 32'(stat_rd[2]),  32'd8);
    chk("error_sticky",        32'(error[2]),    32'd1);
    chk("timeout_done_once",   32'(done_cnt[2]), 32'd1);
`else
    repeat (100) @(negedge clk);
    chk("no_timeout_error", 32'(error[2]),     32'd0);
    chk("still_polling",    32'(busy[2]),      32'd1);
    chk("no_done",          32'(done_cnt[2]),  32'd0);
    chk("polls_continue",   32'(stat_rd[2] > 8), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
